// File: rtl/sram_mem_ctrl.sv
// Two-phase (low/high half-word) sequencer for 32-bit loads/stores onto a 16-bit async SRAM.
// Optional last-read tag bypass enabled by defining SRAM_LASTRD_EN.
module sram_mem_ctrl #(
    parameter int BASE_ADDR = 1024,
    parameter int SRAM_AW   = 18,
    parameter int WAIT_CYC  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n
);

    localparam int WW = SRAM_AW - 1;
    localparam int CW = (WAIT_CYC > 0) ? $clog2(WAIT_CYC + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYC);

    typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              is_wr_q, is_wr_d;
    logic [WW-1:0]     word_q, word_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [SRAM_AW-1:0] addr_q, addr_d;
    logic [15:0]       dq_q, dq_d;
    logic              oe_q, oe_d;
    logic              we_n_q, we_n_d;

    logic [31:0]       byte_off;
    logic [WW-1:0]     req_word;
    logic              phase_end;

`ifdef SRAM_LASTRD_EN
    logic              tag_vld_q, tag_vld_d;
    logic [WW-1:0]     tag_word_q, tag_word_d;
    logic              tag_hit;
`endif

    // Word index wraps modulo 2^(SRAM_AW-1); addresses below BASE_ADDR alias to the top.
    assign byte_off  = address - 32'(BASE_ADDR);
    assign req_word  = WW'(byte_off >> 2);
    assign phase_end = (cnt_q == CNT_LAST);

`ifdef SRAM_LASTRD_EN
    assign tag_hit = tag_vld_q && (tag_word_q == req_word);
`endif

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        is_wr_d = is_wr_q;
        word_d  = word_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef SRAM_LASTRD_EN
        tag_vld_d  = tag_vld_q;
        tag_word_d = tag_word_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (rd_en || wr_en) begin
                    is_wr_d = wr_en;
                    word_d  = req_word;
                    wdata_d = wdata;
                    cnt_d   = '0;
                    state_d = S_LO;
`ifdef SRAM_LASTRD_EN
                    if (wr_en) begin
                        tag_vld_d = 1'b0;
                    end else if (tag_hit) begin
                        state_d = S_DONE;
                    end
`endif
                end
            end
            S_LO: begin
                if (phase_end) begin
                    cnt_d   = '0;
                    state_d = S_HI;
                    if (!is_wr_q) rdata_d[15:0] = sram_dq_in;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_HI: begin
                if (phase_end) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                    if (!is_wr_q) begin
                        rdata_d[31:16] = sram_dq_in;
`ifdef SRAM_LASTRD_EN
                        tag_vld_d  = 1'b1;
                        tag_word_d = word_q;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Pins are registered from the next state so they change on the edge entering a phase.
        addr_d = addr_q;
        dq_d   = dq_q;
        oe_d   = 1'b0;
        we_n_d = 1'b1;
        if (state_d == S_LO || state_d == S_HI) begin
            addr_d = {word_d, (state_d == S_HI)};
            if (is_wr_d) begin
                dq_d   = (state_d == S_HI) ? wdata_d[31:16] : wdata_d[15:0];
                oe_d   = 1'b1;
                we_n_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            is_wr_q <= 1'b0;
            word_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            addr_q  <= '0;
            dq_q    <= '0;
            oe_q    <= 1'b0;
            we_n_q  <= 1'b1;
`ifdef SRAM_LASTRD_EN
            tag_vld_q  <= 1'b0;
            tag_word_q <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            is_wr_q <= is_wr_d;
            word_q  <= word_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            dq_q    <= dq_d;
            oe_q    <= oe_d;
            we_n_q  <= we_n_d;
`ifdef SRAM_LASTRD_EN
            tag_vld_q  <= tag_vld_d;
            tag_word_q <= tag_word_d;
`endif
        end
    end

    assign ready       = (state_q == S_DONE) || (state_q == S_IDLE && !rd_en && !wr_en);
    assign rdata       = rdata_q;
    assign sram_addr   = addr_q;
    assign sram_dq_out = dq_q;
    assign sram_dq_oe  = oe_q;
    assign sram_we_n   = we_n_q;

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Directed bench for sram_mem_ctrl with a small behavioural async SRAM model.
// Define SRAM_LASTRD_EN for the bench and RTL together to exercise the tag bypass.
module tb_sram_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;

    int total = 0;
    int bad   = 0;

    sram_mem_ctrl dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
        .address(address), .wdata(wdata), .rdata(rdata), .ready(ready),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
        .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [256];
    always @(posedge clk) begin
        if (!sram_we_n && sram_dq_oe) mem[sram_addr[7:0]] <= sram_dq_out;
    end
    assign sram_dq_in = mem[sram_addr[7:0]];

    logic [17:0] addr_s [21];
    logic [15:0] dq_s   [21];
    logic        we_s   [21];
    logic        oe_s   [21];
    logic        rdy_s  [21];
    logic [31:0] rd_s   [21];

    task automatic sample(input int c);
        addr_s[c] = sram_addr;
        dq_s[c]   = sram_dq_out;
        we_s[c]   = sram_we_n;
        oe_s[c]   = sram_dq_oe;
        rdy_s[c]  = ready;
        rd_s[c]   = rdata;
    endtask

    // Request starts in a fresh cycle (cycle 0); returns the first cycle with ready=1, or -1.
    task automatic run_op(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input int hold, output int lat);
        @(posedge clk); #1;
        rd_en = rd; wr_en = wr; address = a; wdata = wd;
        #1 sample(0);
        lat = -1;
        for (int c = 1; c <= 20 && lat < 0; c++) begin
            @(posedge clk); #2;
            sample(c);
            if (ready) lat = c;
            if (c == hold) begin rd_en = 1'b0; wr_en = 1'b0; end
        end
        rd_en = 1'b0; wr_en = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ready); end
        total++; if (sram_we_n !== 1'b1) begin bad++; $display("FAIL reset_we_n got=%b exp=1", sram_we_n); end
        total++; if (sram_dq_oe !== 1'b0) begin bad++; $display("FAIL reset_oe got=%b exp=0", sram_dq_oe); end
        total++; if (sram_addr !== 18'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", sram_addr); end
        total++; if (sram_dq_out !== 16'h0) begin bad++; $display("FAIL reset_dq got=%h exp=0", sram_dq_out); end
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        @(posedge clk); #1 rst = 1'b1;
    endtask

    task automatic test_write;
        int lat;
        run_op(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 99, lat);
        total++; if (lat !== 5) begin bad++; $display("FAIL wr_latency got=%0d exp=5", lat); end
        total++; if (rdy_s[0] !== 1'b0) begin bad++; $display("FAIL wr_ready_c0 got=%b exp=0", rdy_s[0]); end
        for (int c = 1; c <= 4; c++) begin
            logic [17:0] ea;
            logic [15:0] ed;
            ea = (c <= 2) ? 18'd0 : 18'd1;
            ed = (c <= 2) ? 16'hBEEF : 16'hDEAD;
            total++; if (addr_s[c] !== ea) begin bad++; $display("FAIL wr_addr c%0d got=%h exp=%h", c, addr_s[c], ea); end
            total++; if (dq_s[c] !== ed) begin bad++; $display("FAIL wr_dq c%0d got=%h exp=%h", c, dq_s[c], ed); end
            total++; if (we_s[c] !== 1'b0 || oe_s[c] !== 1'b1) begin bad++; $display("FAIL wr_strobe c%0d we_n=%b oe=%b exp 0/1", c, we_s[c], oe_s[c]); end
        end
        total++; if (we_s[5] !== 1'b1 || oe_s[5] !== 1'b0) begin bad++; $display("FAIL wr_done_pins we_n=%b oe=%b exp 1/0", we_s[5], oe_s[5]); end
    endtask

    task automatic test_read;
        int lat;
        logic any_we;
        run_op(1'b1, 1'b0, 32'd1024, 32'h0, 99, lat);
        any_we = 1'b0;
        for (int c = 0; c <= 5; c++) if (we_s[c] !== 1'b1 || oe_s[c] !== 1'b0) any_we = 1'b1;
        total++; if (lat !== 5) begin bad++; $display("FAIL rd_latency got=%0d exp=5", lat); end
        total++; if (rd_s[5] !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data got=%h exp=deadbeef", rd_s[5]); end
        total++; if (any_we !== 1'b0) begin bad++; $display("FAIL rd_no_write got=%b exp=0", any_we); end
        total++; if (addr_s[1] !== 18'd0 || addr_s[3] !== 18'd1) begin bad++; $display("FAIL rd_addr got=%h/%h exp=0/1", addr_s[1], addr_s[3]); end
    endtask

    task automatic test_addressing;
        int lat;
        run_op(1'b0, 1'b1, 32'd1028, 32'hCAFEF00D, 99, lat);
        total++; if (addr_s[1] !== 18'd2 || addr_s[3] !== 18'd3) begin bad++; $display("FAIL addr_1028 got=%h/%h exp=2/3", addr_s[1], addr_s[3]); end
        run_op(1'b1, 1'b0, 32'd1028, 32'h0, 99, lat);
        total++; if (rd_s[5] !== 32'hCAFEF00D) begin bad++; $display("FAIL rd_1028 got=%h exp=cafef00d", rd_s[5]); end
        run_op(1'b0, 1'b1, 32'd1020, 32'h0BADC0DE, 99, lat);
        total++; if (addr_s[1] !== 18'h3FFFE || addr_s[3] !== 18'h3FFFF) begin bad++; $display("FAIL addr_wrap got=%h/%h exp=3fffe/3ffff", addr_s[1], addr_s[3]); end
        run_op(1'b1, 1'b0, 32'd1020, 32'h0, 99, lat);
        total++; if (rd_s[5] !== 32'h0BADC0DE || lat !== 5) begin bad++; $display("FAIL rd_wrap got=%h lat=%0d exp=0badc0de lat=5", rd_s[5], lat); end
    endtask

    task automatic test_both_req;
        int lat;
        run_op(1'b1, 1'b1, 32'd1024, 32'h12345678, 99, lat);
        total++; if (we_s[1] !== 1'b0 || we_s[3] !== 1'b0) begin bad++; $display("FAIL both_we got=%b/%b exp=0/0", we_s[1], we_s[3]); end
        total++; if (rd_s[5] !== 32'h0BADC0DE) begin bad++; $display("FAIL both_rdata got=%h exp=0badc0de", rd_s[5]); end
        total++; if (mem[0] !== 16'h5678 || mem[1] !== 16'h1234) begin bad++; $display("FAIL both_mem got=%h/%h exp=5678/1234", mem[0], mem[1]); end
    endtask

    task automatic test_dropped;
        int lat;
        run_op(1'b0, 1'b1, 32'd1040, 32'h55AA33CC, 1, lat);
        total++; if (lat !== 5) begin bad++; $display("FAIL drop_latency got=%0d exp=5", lat); end
        total++; if (mem[8] !== 16'h33CC || mem[9] !== 16'h55AA) begin bad++; $display("FAIL drop_mem got=%h/%h exp=33cc/55aa", mem[8], mem[9]); end
    endtask

    task automatic test_back_to_back;
        int lat;
        run_op(1'b0, 1'b1, 32'd1044, 32'hA5A5A5A5, 99, lat);
        total++; if (addr_s[1] !== 18'd10 || lat !== 5) begin bad++; $display("FAIL b2b_first addr=%h lat=%0d exp=a/5", addr_s[1], lat); end
        run_op(1'b0, 1'b1, 32'd1048, 32'h5A5A5A5A, 99, lat);
        total++; if (rdy_s[0] !== 1'b0 || lat !== 5) begin bad++; $display("FAIL b2b_second rdy0=%b lat=%0d exp=0/5", rdy_s[0], lat); end
        total++; if (addr_s[1] !== 18'd12 || mem[12] !== 16'h5A5A) begin bad++; $display("FAIL b2b_addr addr=%h mem=%h exp=c/5a5a", addr_s[1], mem[12]); end
    endtask

    task automatic test_reset_mid;
        int lat;
        @(posedge clk); #1;
        wr_en = 1'b1; address = 32'd1036; wdata = 32'h11112222;
        repeat (3) @(posedge clk);
        #2;
        total++; if (sram_we_n !== 1'b0 || sram_addr !== 18'd7) begin bad++; $display("FAIL mid_hi we_n=%b addr=%h exp=0/7", sram_we_n, sram_addr); end
        rst = 1'b0; wr_en = 1'b0;
        @(posedge clk); #2;
        total++; if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin bad++; $display("FAIL mid_pins we_n=%b oe=%b exp=1/0", sram_we_n, sram_dq_oe); end
        total++; if (ready !== 1'b1 || rdata !== 32'h0) begin bad++; $display("FAIL mid_state ready=%b rdata=%h exp=1/0", ready, rdata); end
        rst = 1'b1;
        run_op(1'b1, 1'b0, 32'd1024, 32'h0, 99, lat);
        total++; if (lat !== 5 || rd_s[5] !== 32'h12345678) begin bad++; $display("FAIL mid_fresh lat=%0d rdata=%h exp=5/12345678", lat, rd_s[5]); end
    endtask

    task automatic test_lastrd;
        int lat;
        int exp_lat;
        logic [17:0] exp_a1;
`ifdef SRAM_LASTRD_EN
        exp_lat = 1; exp_a1 = 18'd5;
`else
        exp_lat = 5; exp_a1 = 18'd4;
`endif
        run_op(1'b0, 1'b1, 32'd1032, 32'h77778888, 99, lat);
        run_op(1'b1, 1'b0, 32'd1032, 32'h0, 99, lat);
        total++; if (lat !== 5 || rd_s[5] !== 32'h77778888) begin bad++; $display("FAIL tag_first lat=%0d rdata=%h exp=5/77778888", lat, rd_s[5]); end
        run_op(1'b1, 1'b0, 32'd1032, 32'h0, 99, lat);
        total++; if (lat !== exp_lat) begin bad++; $display("FAIL tag_repeat_lat got=%0d exp=%0d", lat, exp_lat); end
        total++; if (addr_s[1] !== exp_a1) begin bad++; $display("FAIL tag_repeat_addr got=%h exp=%h", addr_s[1], exp_a1); end
        total++; if (rd_s[exp_lat] !== 32'h77778888) begin bad++; $display("FAIL tag_repeat_data got=%h exp=77778888", rd_s[exp_lat]); end
        run_op(1'b0, 1'b1, 32'd1032, 32'h9999AAAA, 99, lat);
        run_op(1'b1, 1'b0, 32'd1032, 32'h0, 99, lat);
        total++; if (lat !== 5 || rd_s[5] !== 32'h9999AAAA) begin bad++; $display("FAIL tag_after_wr lat=%0d rdata=%h exp=5/9999aaaa", lat, rd_s[5]); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_addressing();
        test_both_req();
        test_dropped();
        test_back_to_back();
        test_reset_mid();
        test_lastrd();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
